step_controller: RTL and testbench

Single-clock button-driven step sequencer for the board-level LED counter datapath. Synchronises and debounces one active-low push-button, runs a press/hold/auto-repeat state machine timed by an internal tick divider, and steps a WIDTH-bit modulo counter up or down. Drives the LED value and odd flag directly. Sits between a board KEY input and LEDR, with every register on the main clock.

---
 rtl/step_controller.sv | 163 ++++++++++++++++
 tb/tb_step_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/step_controller.sv
// Button-driven step sequencer: synchronise and debounce key_n, then run a press/hold/auto-repeat
// FSM paced by a tick divider that steps a WIDTH-bit modulo counter up or down.
//
//   state  | meaning
//   IDLE   | button released; waiting for the debounced press
//   HOLD   | entry step taken; counting ticks until the first auto-repeat
//   REPEAT | auto-repeat; one step per tick while the button stays held
module step_controller #(
   parameter int WIDTH        = 2,
   parameter int DEBOUNCE     = 500000,
   parameter int TICK_DIV     = 25000000,
   parameter int REPEAT_DELAY = 2
) (
   input  logic             clk,
   input  logic             RESET_N,
   input  logic             key_n,
   input  logic             dir,
   input  logic             clr,
   output logic [WIDTH-1:0] value,
   output logic             odd,
   output logic             step,
   output logic             wrap
);

   localparam int DB_W = $clog2(DEBOUNCE + 1);
   localparam int TK_W = $clog2(TICK_DIV);
   localparam int RC_W = $clog2(REPEAT_DELAY + 1);

   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
   localparam logic [TK_W-1:0]  TK_LAST  = TK_W'(TICK_DIV - 1);
   localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(REPEAT_DELAY - 1);
   localparam logic [WIDTH-1:0] VAL_MAX  = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              sync1_q, sync2_q;
   logic              db_q, db_d;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
   logic [TK_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic [RC_W-1:0]   rep_cnt_q, rep_cnt_d;
   logic [WIDTH-1:0]  value_q, value_d;
   logic              step_q, step_d;
   logic              wrap_q, wrap_d;
   logic              pressed_s;
   logic              tick;
   logic              fire;
   logic              timing;

   // Sync flops reset to the released level so a held key still needs a full debounce after reset.
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         db_q       <= 1'b0;
         db_cnt_q   <= '0;
         tick_cnt_q <= '0;
         rep_cnt_q  <= '0;
         state_q    <= IDLE;
         value_q    <= '0;
         step_q     <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         sync1_q    <= key_n;
         sync2_q    <= sync1_q;
         db_q       <= db_d;
         db_cnt_q   <= db_cnt_d;
         tick_cnt_q <= tick_cnt_d;
         rep_cnt_q  <= rep_cnt_d;
         state_q    <= state_d;
         value_q    <= value_d;
         step_q     <= step_d;
         wrap_q     <= wrap_d;
      end
   end

   assign pressed_s = ~sync2_q;

   always_comb begin
      db_d     = db_q;
      db_cnt_d = '0;
      if (pressed_s != db_q) begin
         if (db_cnt_q == DB_LAST) begin
            db_d = ~db_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
   end

   assign timing = (state_q == HOLD) || (state_q == REPEAT);
   assign tick   = timing && (tick_cnt_q == TK_LAST);

   always_comb begin
      tick_cnt_d = '0;
      if (timing) begin
         tick_cnt_d = tick ? '0 : tick_cnt_q + TK_W'(1);
      end
   end

   // A release (db low) is checked before the tick so it always wins.
   always_comb begin
      state_d   = state_q;
      rep_cnt_d = rep_cnt_q;
      fire      = 1'b0;
      case (state_q)
         IDLE: begin
            rep_cnt_d = '0;
            if (db_q) begin
               state_d = HOLD;
               fire    = 1'b1;
            end
         end
         HOLD: begin
            if (!db_q) begin
               state_d = IDLE;
            end else if (tick) begin
               if (rep_cnt_q == RC_LAST) begin
                  state_d = REPEAT;
                  fire    = 1'b1;
               end else begin
                  rep_cnt_d = rep_cnt_q + RC_W'(1);
               end
            end
         end
         REPEAT: begin
            if (!db_q) begin
               state_d = IDLE;
            end else if (tick) begin
               fire = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      value_d = value_q;
      wrap_d  = 1'b0;
      step_d  = fire;
      if (clr) begin
         value_d = '0;
      end else if (fire) begin
         if (dir) begin
            value_d = value_q + WIDTH'(1);
            wrap_d  = (value_q == VAL_MAX);
         end else begin
            value_d = value_q - WIDTH'(1);
            wrap_d  = (value_q == '0);
         end
      end
   end

   assign value = value_q;
   assign odd   = value_q[0];
   assign step  = step_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_step_controller.sv
// Bench for step_controller: directed scenarios followed by random key/dir/clr traffic, all
// outputs compared every cycle against an event-level model of the press/hold/repeat rules.
module tb_step_controller;

   localparam int W  = 2;
   localparam int DB = 4;
   localparam int TD = 8;
   localparam int RD = 2;
   localparam int VMASK = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         RESET_N = 1'b0;
   logic         key_n = 1'b1;
   logic         dir = 1'b1;
   logic         clr = 1'b0;
   logic [W-1:0] value;
   logic         odd, step, wrap;

   int checks = 0;
   int passed = 0;

   // model state
   int m_t = 0;
   int m_s1, m_s2, m_db, m_run, m_held, m_E;
   int m_val, m_step, m_wrap;

   int steps_q[$];
   int vals_q[$];
   int wraps_q[$];
   int k_first;

   step_controller #(.WIDTH(W), .DEBOUNCE(DB), .TICK_DIV(TD), .REPEAT_DELAY(RD)) dut (
      .clk(clk), .RESET_N(RESET_N), .key_n(key_n), .dir(dir), .clr(clr),
      .value(value), .odd(odd), .step(step), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_s1 = 1; m_s2 = 1; m_db = 0; m_run = 0; m_held = 0; m_E = 0;
      m_val = 0; m_step = 0; m_wrap = 0;
   endtask

   // Steps come from the press rules: one on entry, one at E+RD*TD, then every TD edges.
   task automatic model_edge(input int k, input int d, input int c);
      int fire;
      int pressed;
      m_t++;
      fire = 0;
      if (!m_held) begin
         if (m_db) begin
            fire = 1; m_held = 1; m_E = m_t;
         end
      end else if (!m_db) begin
         m_held = 0;
      end else if ((m_t - m_E) >= RD * TD && ((m_t - m_E) % TD) == 0) begin
         fire = 1;
      end
      pressed = m_s2 ? 0 : 1;
      if (pressed != m_db) begin
         m_run++;
         if (m_run == DB) begin
            m_db = pressed; m_run = 0;
         end
      end else begin
         m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = k;
      m_step = fire;
      m_wrap = 0;
      if (c) begin
         m_val = 0;
      end else if (fire) begin
         if (d) begin
            m_wrap = (m_val == VMASK);
            m_val  = (m_val + 1) & VMASK;
         end else begin
            m_wrap = (m_val == 0);
            m_val  = (m_val + VMASK) & VMASK;
         end
      end
   endtask

   task automatic cyc(input logic k, input logic d, input logic c);
      key_n = k; dir = d; clr = c;
      @(posedge clk);
      model_edge(int'(k), int'(d), int'(c));
      #1;
      chk("value", value, m_val);
      chk("odd", odd, m_val & 1);
      chk("step", step, m_step);
      chk("wrap", wrap, m_wrap);
      if (step === 1'b1) begin
         steps_q.push_back(m_t);
         vals_q.push_back(int'(value));
         wraps_q.push_back(int'(wrap));
      end
   endtask

   task automatic clear_log();
      steps_q.delete(); vals_q.delete(); wraps_q.delete();
   endtask

   // Called just after a posedge: asserts reset between edges and checks the async clear.
   task automatic pulse_reset(input string tag);
      #1 RESET_N = 1'b0;
      #1;
      chk({tag, "_value"}, value, 0);
      chk({tag, "_odd"}, odd, 0);
      chk({tag, "_step"}, step, 0);
      chk({tag, "_wrap"}, wrap, 0);
      model_reset();
      #1 RESET_N = 1'b1;
   endtask

   initial begin
      int exp_off[6];
      int exp_val[6];
      int lvl, run;
      exp_off = '{0, 16, 24, 32, 40, 48};
      exp_val = '{1, 2, 3, 0, 1, 2};
      model_reset();

      #12;
      chk("rst_value", value, 0);
      chk("rst_odd", odd, 0);
      chk("rst_step", step, 0);
      chk("rst_wrap", wrap, 0);
      @(posedge clk);
      #1 RESET_N = 1'b1;
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);

      // clean press
      clear_log();
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 1'b1, 1'b0);
         if (i == 0) k_first = m_t;
      end
      for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b0);
      chk("press_count", steps_q.size(), 1);
      if (steps_q.size() >= 1) begin
         chk("press_latency", steps_q[0] - k_first, 6);
         chk("press_value", vals_q[0], 1);
         chk("press_wrap", wraps_q[0], 0);
      end
      chk("press_odd", odd, 1);

      // bounce
      clear_log();
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b0);
      chk("bounce_count", steps_q.size(), 0);
      chk("bounce_value", value, 1);

      // mid-cycle reset, then long hold from zero
      pulse_reset("rst_mid");
      clear_log();
      for (int i = 0; i < 56; i++) begin
         cyc(1'b0, 1'b1, 1'b0);
         if (i == 0) k_first = m_t;
      end
      for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b0);
      chk("hold_count", steps_q.size(), 6);
      if (steps_q.size() == 6) begin
         chk("hold_entry", steps_q[0] - k_first, 6);
         for (int i = 0; i < 6; i++) begin
            chk($sformatf("hold_off%0d", i), steps_q[i] - steps_q[0], exp_off[i]);
            chk($sformatf("hold_val%0d", i), vals_q[i], exp_val[i]);
            chk($sformatf("hold_wrap%0d", i), wraps_q[i], (i == 3) ? 1 : 0);
         end
      end

      // down-count from zero
      cyc(1'b1, 1'b1, 1'b1);
      chk("clr_only", value, 0);
      clear_log();
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0);
      chk("down_count", steps_q.size(), 1);
      if (steps_q.size() >= 1) begin
         chk("down_value", vals_q[0], 3);
         chk("down_wrap", wraps_q[0], 1);
      end
      chk("down_odd", odd, 1);

      // clr on the first repeat step, which would otherwise wrap 0 -> 3
      clear_log();
      for (int n = 1; n <= 40; n++) begin
         cyc(1'b0, (n <= 7) ? 1'b1 : 1'b0, (n == 23) ? 1'b1 : 1'b0);
         if (n == 23) begin
            chk("clr_step", step, 1);
            chk("clr_value", value, 0);
            chk("clr_wrap", wrap, 0);
         end
      end

      // reset in REPEAT with the key still held
      pulse_reset("rst_rep");
      clear_log();
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 1'b1, 1'b0);
         if (i == 0) k_first = m_t;
      end
      chk("rerst_count", steps_q.size(), 1);
      if (steps_q.size() >= 1) begin
         chk("rerst_latency", steps_q[0] - k_first, 6);
         chk("rerst_value", vals_q[0], 1);
      end
      for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b0);

      // random traffic
      lvl = 1;
      run = 0;
      for (int i = 0; i < 1500; i++) begin
         if (run == 0) begin
            lvl = $urandom_range(0, 1);
            run = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(4, 45);
         end
         run--;
         cyc(lvl[0], 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
